// File: rtl/cva6_rd_arbiter.sv
// Round-robin arbiter sharing one axi_shim read port between NumReq refill requesters.
// The requester index is prepended to the AXI ID, and read beats are routed back by it.
module cva6_rd_arbiter #(
    parameter  int NumReq         = 2,
    parameter  int AddrWidth      = 64,
    parameter  int DataWidth      = 64,
    parameter  int IdWidth        = 4,
    parameter  int BlenWidth      = 2,
    parameter  int MaxOutstanding = 2,
    localparam int IdxW           = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq-1:0]           req_i,
    output logic [NumReq-1:0]           req_gnt_o,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    input  logic [NumReq*BlenWidth-1:0] req_blen_i,
    input  logic [NumReq*3-1:0]         req_size_i,
    input  logic [NumReq*IdWidth-1:0]   req_id_i,
    output logic [NumReq-1:0]           rsp_valid_o,
    input  logic [NumReq-1:0]           rsp_rdy_i,
    output logic [DataWidth-1:0]        rsp_data_o,
    output logic                        rsp_last_o,
    output logic [IdWidth-1:0]          rsp_id_o,
    output logic                        rsp_exokay_o,
    output logic                        rd_req_o,
    input  logic                        rd_gnt_i,
    output logic [AddrWidth-1:0]        rd_addr_o,
    output logic [BlenWidth-1:0]        rd_blen_o,
    output logic [2:0]                  rd_size_o,
    output logic [IdWidth+IdxW-1:0]     rd_id_o,
    output logic                        rd_lock_o,
    output logic                        rd_rdy_o,
    input  logic                        rd_valid_i,
    input  logic                        rd_last_i,
    input  logic [DataWidth-1:0]        rd_data_i,
    input  logic [IdWidth+IdxW-1:0]     rd_id_i,
    input  logic                        rd_exokay_i,
    output logic                        idle_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e            r_state;
    logic [IdxW-1:0]   r_rr;
    logic [IdxW-1:0]   r_sel;
    logic [CntW-1:0]   r_cnt [NumReq];

    logic [NumReq-1:0] w_elig;
    logic              w_any;
    logic [IdxW-1:0]   w_win;
    logic [IdxW-1:0]   w_src;
    logic              w_hold;
    logic              w_fire;
    logic [IdxW-1:0]   w_o;
    logic              w_o_ok;
    logic              w_rdy;
    logic              w_ret;
    logic [NumReq-1:0] w_dec;
    logic              w_cnt_zero;

    function automatic logic [IdxW-1:0] f_next(input logic [IdxW-1:0] idx);
        f_next = (idx == IdxW'(NumReq - 1)) ? {IdxW{1'b0}} : idx + {{(IdxW-1){1'b0}}, 1'b1};
    endfunction

    // Eligibility, round-robin winner and request-side muxing
    always_comb begin
        w_any = 1'b0;
        w_win = {IdxW{1'b0}};
        for (int k = 0; k < NumReq; k++) begin
            w_elig[k] = req_i[k] & (r_cnt[k] < CntW'(MaxOutstanding));
        end
        // Scan from the farthest offset down so the nearest eligible index to r_rr wins.
        for (int i = NumReq - 1; i >= 0; i--) begin
            w_win = w_elig[IdxW'((int'(r_rr) + i) % NumReq)] ? IdxW'((int'(r_rr) + i) % NumReq) : w_win;
            w_any = w_any | w_elig[IdxW'((int'(r_rr) + i) % NumReq)];
        end
        w_hold    = (r_state == ST_HOLD);
        w_src     = w_hold ? r_sel : w_win;
        rd_req_o  = w_hold | w_any;
        w_fire    = rd_req_o & rd_gnt_i;
        for (int k = 0; k < NumReq; k++) begin
            req_gnt_o[k] = w_fire & (w_src == IdxW'(k));
        end
        rd_addr_o = req_addr_i[int'(w_src)*AddrWidth +: AddrWidth];
        rd_blen_o = req_blen_i[int'(w_src)*BlenWidth +: BlenWidth];
        rd_size_o = req_size_i[int'(w_src)*3 +: 3];
        rd_id_o   = {w_src, req_id_i[int'(w_src)*IdWidth +: IdWidth]};
        rd_lock_o = 1'b0;
    end

    // Response routing by the index bits of the returned ID
    always_comb begin
        w_o    = rd_id_i[IdWidth+IdxW-1:IdWidth];
        w_o_ok = ({1'b0, w_o} < (IdxW+1)'(NumReq));
        w_rdy  = ~w_o_ok;
        for (int k = 0; k < NumReq; k++) begin
            rsp_valid_o[k] = rd_valid_i & (w_o == IdxW'(k));
            w_rdy          = w_rdy | (rsp_rdy_i[k] & (w_o == IdxW'(k)));
        end
        w_ret = rd_valid_i & w_rdy & rd_last_i;
        for (int k = 0; k < NumReq; k++) begin
            w_dec[k] = w_ret & (w_o == IdxW'(k));
        end
        rd_rdy_o     = w_rdy;
        rsp_data_o   = rd_data_i;
        rsp_last_o   = rd_last_i;
        rsp_id_o     = rd_id_i[IdWidth-1:0];
        rsp_exokay_o = rd_exokay_i;
    end

    // Idle when nothing is requested, held or outstanding
    always_comb begin
        w_cnt_zero = 1'b1;
        for (int k = 0; k < NumReq; k++) begin
            w_cnt_zero = w_cnt_zero & (r_cnt[k] == {CntW{1'b0}});
        end
        idle_o = ~w_hold & ~(|req_i) & w_cnt_zero;
    end

    // Arbitration FSM: HOLD keeps the AR fields stable until the shim grants
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_rr    <= {IdxW{1'b0}};
            r_sel   <= {IdxW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        if (rd_gnt_i) begin
                            r_rr <= f_next(w_win);
                        end else begin
                            r_sel   <= w_win;
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (rd_gnt_i) begin
                        r_rr    <= f_next(r_sel);
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outstanding burst counters; a stray last beat saturates at zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumReq; k++) begin
                r_cnt[k] <= {CntW{1'b0}};
            end
        end else begin
            for (int k = 0; k < NumReq; k++) begin
                case ({req_gnt_o[k], w_dec[k]})
                    2'b10: r_cnt[k] <= r_cnt[k] + {{(CntW-1){1'b0}}, 1'b1};
                    2'b01: begin
                        if (r_cnt[k] != {CntW{1'b0}}) begin
                            r_cnt[k] <= r_cnt[k] - {{(CntW-1){1'b0}}, 1'b1};
                        end
                    end
                    default: r_cnt[k] <= r_cnt[k];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cva6_rd_arbiter.sv
// Scoreboard bench for cva6_rd_arbiter: stimulus pushes expected grants and beats,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_cva6_rd_arbiter;

    logic          clk;
    logic          rst_ni;
    logic [1:0]    req_i;
    logic [1:0]    req_gnt_o;
    logic [127:0]  req_addr_i;
    logic [3:0]    req_blen_i;
    logic [5:0]    req_size_i;
    logic [7:0]    req_id_i;
    logic [1:0]    rsp_valid_o;
    logic [1:0]    rsp_rdy_i;
    logic [63:0]   rsp_data_o;
    logic          rsp_last_o;
    logic [3:0]    rsp_id_o;
    logic          rsp_exokay_o;
    logic          rd_req_o;
    logic          rd_gnt_i;
    logic [63:0]   rd_addr_o;
    logic [1:0]    rd_blen_o;
    logic [2:0]    rd_size_o;
    logic [4:0]    rd_id_o;
    logic          rd_lock_o;
    logic          rd_rdy_o;
    logic          rd_valid_i;
    logic          rd_last_i;
    logic [63:0]   rd_data_i;
    logic [4:0]    rd_id_i;
    logic          rd_exokay_i;
    logic          idle_o;

    cva6_rd_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .req_gnt_o(req_gnt_o),
        .req_addr_i(req_addr_i), .req_blen_i(req_blen_i), .req_size_i(req_size_i),
        .req_id_i(req_id_i), .rsp_valid_o(rsp_valid_o), .rsp_rdy_i(rsp_rdy_i),
        .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o), .rsp_id_o(rsp_id_o),
        .rsp_exokay_o(rsp_exokay_o), .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i),
        .rd_addr_o(rd_addr_o), .rd_blen_o(rd_blen_o), .rd_size_o(rd_size_o),
        .rd_id_o(rd_id_o), .rd_lock_o(rd_lock_o), .rd_rdy_o(rd_rdy_o),
        .rd_valid_i(rd_valid_i), .rd_last_i(rd_last_i), .rd_data_i(rd_data_i),
        .rd_id_i(rd_id_i), .rd_exokay_i(rd_exokay_i), .idle_o(idle_o)
    );

    localparam logic [63:0] A0 = 64'h0000_0000_8000_1000;
    localparam logic [63:0] A1 = 64'h0000_0000_9000_2000;
    localparam logic [3:0]  ID0 = 4'h5;
    localparam logic [3:0]  ID1 = 4'hA;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [63:0] addr;
        logic [4:0]  id;
    } gnt_t;

    typedef struct packed {
        logic [1:0]  vld;
        logic [63:0] data;
        logic [3:0]  id;
        logic        last;
    } beat_t;

    gnt_t  gnt_q[$];
    beat_t beat_q[$];
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_gnt(input int k);
        gnt_t g;
        g.gnt  = (k == 0) ? 2'b01 : 2'b10;
        g.addr = (k == 0) ? A0 : A1;
        g.id   = (k == 0) ? {1'b0, ID0} : {1'b1, ID1};
        gnt_q.push_back(g);
    endtask

    task automatic push_beat(input int k, input logic [63:0] data, input logic last);
        beat_t b;
        b.vld  = (k == 0) ? 2'b01 : 2'b10;
        b.data = data;
        b.id   = (k == 0) ? ID0 : ID1;
        b.last = last;
        beat_q.push_back(b);
    endtask

    task automatic beat_in(input int k, input logic [63:0] data, input logic last);
        rd_valid_i = 1'b1;
        rd_data_i  = data;
        rd_last_i  = last;
        rd_id_i    = (k == 0) ? {1'b0, ID0} : {1'b1, ID1};
    endtask

    task automatic no_beat();
        rd_valid_i = 1'b0;
        rd_last_i  = 1'b0;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni   = 1'b0;
        req_i    = 2'b00;
        rd_gnt_i = 1'b0;
        no_beat();
        to_pos();
        to_pos();
        rst_ni = 1'b1;
    endtask

    // Monitor: compare every presented grant and accepted beat against the scoreboard
    always @(negedge clk) begin
        if (req_gnt_o != 2'b00) begin
            if (gnt_q.size() == 0) begin
                chk("unexpected_grant", {62'd0, req_gnt_o}, 64'd0);
            end else begin
                gnt_t g;
                g = gnt_q.pop_front();
                chk("grant_vec", {62'd0, req_gnt_o}, {62'd0, g.gnt});
                chk("grant_addr", rd_addr_o, g.addr);
                chk("grant_id", {59'd0, rd_id_o}, {59'd0, g.id});
                chk("grant_blen", {62'd0, rd_blen_o}, 64'd1);
            end
        end
        if ((rsp_valid_o & rsp_rdy_i) != 2'b00) begin
            if (beat_q.size() == 0) begin
                chk("unexpected_beat", {62'd0, rsp_valid_o}, 64'd0);
            end else begin
                beat_t b;
                b = beat_q.pop_front();
                chk("beat_valid", {62'd0, rsp_valid_o}, {62'd0, b.vld});
                chk("beat_data", rsp_data_o, b.data);
                chk("beat_id", {60'd0, rsp_id_o}, {60'd0, b.id});
                chk("beat_last", {63'd0, rsp_last_o}, {63'd0, b.last});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        req_addr_i  = {A1, A0};
        req_blen_i  = {2'b01, 2'b01};
        req_size_i  = {3'd3, 3'd3};
        req_id_i    = {ID1, ID0};
        rsp_rdy_i   = 2'b11;
        rd_data_i   = 64'd0;
        rd_id_i     = 5'd0;
        rd_exokay_i = 1'b0;
        rst_ni      = 1'b0;
        req_i       = 2'b00;
        rd_gnt_i    = 1'b0;
        no_beat();
        to_neg();
        chk("rst_gnt", {62'd0, req_gnt_o}, 64'd0);
        chk("rst_rd_req", {63'd0, rd_req_o}, 64'd0);
        chk("rst_rsp_valid", {62'd0, rsp_valid_o}, 64'd0);
        chk("rst_idle", {63'd0, idle_o}, 64'd1);
        to_pos();
        rst_ni = 1'b1;
        to_pos();

        // Single request, immediate grant, two-beat burst back
        req_i = 2'b01; rd_gnt_i = 1'b1; push_gnt(0);
        to_neg(); chk("t1_rd_id", {59'd0, rd_id_o}, {59'd0, 1'b0, ID0});
        to_pos();
        req_i = 2'b00; rd_gnt_i = 1'b0;
        to_neg(); chk("t1_busy", {63'd0, idle_o}, 64'd0);
        to_pos();
        beat_in(0, 64'h1111_2222_3333_4444, 1'b0); push_beat(0, 64'h1111_2222_3333_4444, 1'b0);
        to_pos();
        beat_in(0, 64'h5555_6666_7777_8888, 1'b1); push_beat(0, 64'h5555_6666_7777_8888, 1'b1);
        to_pos();
        no_beat();
        to_neg(); chk("t1_idle_after_last", {63'd0, idle_o}, 64'd1);
        to_pos();

        // Continuous requests from both, alternating grants from rr=0
        do_reset();
        req_i = 2'b11; rd_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_gnt(i % 2);
            to_pos();
        end
        req_i = 2'b00; rd_gnt_i = 1'b0;
        to_pos();

        // Shim stalls 3 cycles: AR stays on requester 0
        do_reset();
        req_i = 2'b01; rd_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            chk("t3_rd_req", {63'd0, rd_req_o}, 64'd1);
            chk("t3_addr_hold", rd_addr_o, A0);
            to_pos();
            req_i = 2'b11;
        end
        rd_gnt_i = 1'b1; push_gnt(0);
        to_pos();
        req_i = 2'b10; push_gnt(1);
        to_pos();
        req_i = 2'b00; rd_gnt_i = 1'b0;
        to_pos();

        // Outstanding limit on requester 0
        do_reset();
        req_i = 2'b01; rd_gnt_i = 1'b1;
        push_gnt(0); to_pos();
        push_gnt(0); to_pos();
        req_i = 2'b11;
        push_gnt(1); to_pos();
        push_gnt(1); to_pos();
        req_i = 2'b01;
        beat_in(0, 64'hAAAA_0000_BBBB_0001, 1'b1); push_beat(0, 64'hAAAA_0000_BBBB_0001, 1'b1);
        to_neg(); chk("t4_req0_blocked", {63'd0, rd_req_o}, 64'd0);
        to_pos();
        no_beat(); push_gnt(0);
        to_neg(); chk("t4_req0_reenabled", {63'd0, rd_req_o}, 64'd1);
        to_pos();
        req_i = 2'b00; rd_gnt_i = 1'b0;

        // Last beat for requester 1 back-pressured for 2 cycles (cnt1 is at its limit)
        rsp_rdy_i = 2'b01; req_i = 2'b10; rd_gnt_i = 1'b1;
        beat_in(1, 64'hCAFE_F00D_0000_0002, 1'b1);
        for (int i = 0; i < 2; i++) begin
            to_neg();
            chk("t5_rd_rdy_low", {63'd0, rd_rdy_o}, 64'd0);
            chk("t5_rsp_valid", {62'd0, rsp_valid_o}, 64'd2);
            chk("t5_no_dec", {63'd0, rd_req_o}, 64'd0);
            to_pos();
        end
        rsp_rdy_i = 2'b11; push_beat(1, 64'hCAFE_F00D_0000_0002, 1'b1);
        to_neg();
        chk("t5_rd_rdy_high", {63'd0, rd_rdy_o}, 64'd1);
        chk("t5_dec_not_yet", {63'd0, rd_req_o}, 64'd0);
        to_pos();
        no_beat(); push_gnt(1);
        to_neg(); chk("t5_req1_reenabled", {63'd0, rd_req_o}, 64'd1);
        to_pos();
        req_i = 2'b00; rd_gnt_i = 1'b0;
        to_pos();

        // Reset asserted while holding a request with cnt0=1
        do_reset();
        req_i = 2'b01; rd_gnt_i = 1'b1; push_gnt(0);
        to_pos();
        rd_gnt_i = 1'b0;
        to_neg(); chk("t6_hold_req", {63'd0, rd_req_o}, 64'd1);
        to_pos();
        #2;
        rst_ni = 1'b0; req_i = 2'b00;
        to_neg();
        chk("t6_rst_rd_req", {63'd0, rd_req_o}, 64'd0);
        chk("t6_rst_idle", {63'd0, idle_o}, 64'd1);
        to_pos();
        rst_ni = 1'b1;
        to_neg(); chk("t6_post_idle", {63'd0, idle_o}, 64'd1);
        to_pos();

        to_pos();
        chk("gnt_queue_empty", 64'(gnt_q.size()), 64'd0);
        chk("beat_queue_empty", 64'(beat_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
